// File: rtl/rr_log_packetizer_pkg.sv
// Shared fpgarr types: record widths, packetizer state encoding and header layout.
// The packetizer and its helpers import this package.
package rr_log_packetizer_pkg;

  localparam int RR_CHANNEL_WIDTH_BITS = 16;
  localparam int RR_MAX_LOGB           = 16;

  localparam int RR_AW_WIDTH = 72;
  localparam int RR_W_WIDTH  = 296;
  localparam int RR_AR_WIDTH = 72;

  // Channel 0 = AW, 1 = W, 2 = AR (entry 0 in the least significant slot)
  localparam logic [3*RR_CHANNEL_WIDTH_BITS-1:0] RR_DEFAULT_WIDTHS = {
    RR_CHANNEL_WIDTH_BITS'(RR_AR_WIDTH),
    RR_CHANNEL_WIDTH_BITS'(RR_W_WIDTH),
    RR_CHANNEL_WIDTH_BITS'(RR_AW_WIDTH)
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } rr_pkt_state_e;

  // Header beat: logb mask at the LSBs, loge mask immediately above it, rest zero.
  localparam int RR_HDR_LOGB_LSB = 0;

  typedef logic [RR_MAX_LOGB*RR_CHANNEL_WIDTH_BITS-1:0] rr_width_vec_t;

  function automatic int rr_width_offset(input rr_width_vec_t widths, input int idx);
    int s;
    s = 0;
    for (int k = 0; k < idx; k++) begin
      s += int'(widths[k*RR_CHANNEL_WIDTH_BITS +: RR_CHANNEL_WIDTH_BITS]);
    end
    return s;
  endfunction

endpackage

// File: rtl/rr_next_set_bit.sv
// Finds the lowest set bit of mask_i at or above start_i.
// start_i is one bit wider than an index so "past the top" can be expressed.
module rr_next_set_bit #(
  parameter  int WIDTH = 8,
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] mask_i,
  input  logic [IDX_W:0]   start_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  // Scanning downward lets the lowest qualifying bit win.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (mask_i[i] && (i >= int'(start_i))) begin
        found_o = 1'b1;
        idx_o   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/rr_log_packetizer.sv
// Packs one snapshot of the record/replay channel loggers into a header beat
// followed by one LSB-aligned beat per captured data channel.
module rr_log_packetizer
  import rr_log_packetizer_pkg::*;
#(
  parameter  int LOGB_CNT  = 3,
  parameter  int LOGE_CNT  = 5,
  parameter  logic [LOGB_CNT-1:0][RR_CHANNEL_WIDTH_BITS-1:0] CHANNEL_WIDTHS = RR_DEFAULT_WIDTHS,
  parameter  int OUT_WIDTH = 512,
  localparam int DATA_W    = rr_width_offset(rr_width_vec_t'(CHANNEL_WIDTHS), LOGB_CNT)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [LOGB_CNT-1:0]  logb_valid,
  input  logic [DATA_W-1:0]    logb_data,
  input  logic [LOGE_CNT-1:0]  loge_valid,
  output logic                 log_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic [31:0]          pkt_cnt
);

  localparam int PTR_W = (LOGB_CNT > 1) ? $clog2(LOGB_CNT) : 1;

  rr_pkt_state_e        state_q;
  logic [LOGB_CNT-1:0]  logb_mask_q;
  logic [LOGE_CNT-1:0]  loge_mask_q;
  logic [PTR_W-1:0]     ptr_q;
  logic                 out_valid_q;
  logic [31:0]          pkt_cnt_q;
  logic [OUT_WIDTH-1:0] data_q  [LOGB_CNT];
  logic [OUT_WIDTH-1:0] chan_in [LOGB_CNT];

  logic                 first_found;
  logic [PTR_W-1:0]     first_idx;
  logic                 above_found;
  logic [PTR_W-1:0]     above_idx;
  logic [PTR_W:0]       start_above;

  if (LOGB_CNT + LOGE_CNT > OUT_WIDTH) begin : g_err_hdr
    $error("rr_log_packetizer: header (LOGB_CNT+LOGE_CNT) wider than OUT_WIDTH");
  end
  if (LOGE_CNT < LOGB_CNT) begin : g_err_loge
    $error("rr_log_packetizer: LOGE_CNT must be >= LOGB_CNT");
  end
  if (LOGB_CNT > RR_MAX_LOGB) begin : g_err_max
    $error("rr_log_packetizer: LOGB_CNT exceeds RR_MAX_LOGB");
  end

  for (genvar g = 0; g < LOGB_CNT; g++) begin : g_chan
    localparam int OFF = rr_width_offset(rr_width_vec_t'(CHANNEL_WIDTHS), g);
    localparam int CW  = int'(CHANNEL_WIDTHS[g]);
    if (CW > OUT_WIDTH) begin : g_err_w
      $error("rr_log_packetizer: channel width exceeds OUT_WIDTH");
    end
    assign chan_in[g] = OUT_WIDTH'(logb_data[OFF +: CW]);
  end

  assign start_above = {1'b0, ptr_q} + (PTR_W + 1)'(1);

  rr_next_set_bit #(.WIDTH(LOGB_CNT)) u_first (
    .mask_i  (logb_mask_q),
    .start_i ('0),
    .found_o (first_found),
    .idx_o   (first_idx)
  );

  rr_next_set_bit #(.WIDTH(LOGB_CNT)) u_above (
    .mask_i  (logb_mask_q),
    .start_i (start_above),
    .found_o (above_found),
    .idx_o   (above_idx)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      logb_mask_q <= '0;
      loge_mask_q <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      pkt_cnt_q   <= '0;
      for (int i = 0; i < LOGB_CNT; i++) data_q[i] <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if ((|logb_valid) || (|loge_valid)) begin
            logb_mask_q <= logb_valid;
            loge_mask_q <= loge_valid;
            for (int i = 0; i < LOGB_CNT; i++) begin
              if (logb_valid[i]) data_q[i] <= chan_in[i];
            end
            state_q     <= ST_HDR;
            out_valid_q <= 1'b1;
          end
        end
        ST_HDR: begin
          if (out_ready) begin
            if (!first_found) begin
              state_q     <= ST_IDLE;
              out_valid_q <= 1'b0;
              pkt_cnt_q   <= pkt_cnt_q + 32'd1;
            end else begin
              state_q <= ST_DATA;
              ptr_q   <= first_idx;
            end
          end
        end
        ST_DATA: begin
          if (out_ready) begin
            if (above_found) begin
              ptr_q <= above_idx;
            end else begin
              state_q     <= ST_IDLE;
              out_valid_q <= 1'b0;
              pkt_cnt_q   <= pkt_cnt_q + 32'd1;
            end
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Beat content is a pure mux of registers, so it cannot move while stalled.
  always_comb begin
    out_data = '0;
    out_last = 1'b0;
    case (state_q)
      ST_HDR: begin
        out_data[RR_HDR_LOGB_LSB +: LOGB_CNT]            = logb_mask_q;
        out_data[RR_HDR_LOGB_LSB + LOGB_CNT +: LOGE_CNT] = loge_mask_q;
        out_last = !first_found;
      end
      ST_DATA: begin
        out_data = data_q[ptr_q];
        out_last = !above_found;
      end
      default: begin
        out_data = '0;
        out_last = 1'b0;
      end
    endcase
  end

  assign log_ready = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign pkt_cnt   = pkt_cnt_q;

endmodule

// File: tb/tb_rr_log_packetizer.sv
// Bench for rr_log_packetizer: queue-based packet model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_rr_log_packetizer;
  import rr_log_packetizer_pkg::*;

  localparam int NB = 3;
  localparam int NE = 5;
  localparam int OW = 512;
  localparam int DW = RR_AW_WIDTH + RR_W_WIDTH + RR_AR_WIDTH;

  typedef struct {
    logic [OW-1:0] d;
    logic          l;
  } beat_t;

  logic          clk;
  logic          rstn;
  logic [NB-1:0] logb_valid;
  logic [DW-1:0] logb_data;
  logic [NE-1:0] loge_valid;
  logic          log_ready;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          out_last;
  logic [31:0]   pkt_cnt;

  beat_t         exp_q[$];
  beat_t         acc_q[$];
  logic [31:0]   m_cnt;
  int            n_checks;
  int            n_fail;
  logic          p_stall;
  logic [OW-1:0] p_data;
  logic          p_last;

  rr_log_packetizer dut (
    .clk        (clk),
    .rstn       (rstn),
    .logb_valid (logb_valid),
    .logb_data  (logb_data),
    .loge_valid (loge_valid),
    .log_ready  (log_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .pkt_cnt    (pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int chan_w(input int i);
    case (i)
      0:       return RR_AW_WIDTH;
      1:       return RR_W_WIDTH;
      default: return RR_AR_WIDTH;
    endcase
  endfunction

  function automatic int chan_off(input int i);
    int s;
    s = 0;
    for (int k = 0; k < i; k++) s += chan_w(k);
    return s;
  endfunction

  task automatic chk(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected packet: header, then each set logb channel in ascending order.
  task automatic push_pkt(input logic [NB-1:0] lv, input logic [NE-1:0] ev, input logic [DW-1:0] d);
    beat_t b;
    int    hi;
    b.d = '0;
    for (int i = 0; i < NB; i++) b.d[i] = lv[i];
    for (int j = 0; j < NE; j++) b.d[NB+j] = ev[j];
    b.l = (lv == '0);
    exp_q.push_back(b);
    hi = -1;
    for (int i = 0; i < NB; i++) if (lv[i]) hi = i;
    for (int i = 0; i < NB; i++) begin
      if (lv[i]) begin
        b.d = '0;
        for (int k = 0; k < chan_w(i); k++) b.d[k] = d[chan_off(i)+k];
        b.l = (i == hi);
        exp_q.push_back(b);
      end
    end
  endtask

  always @(negedge rstn) begin
    exp_q.delete();
    m_cnt = '0;
  end

  always @(posedge clk) begin
    if (!rstn) begin
      exp_q.delete();
      m_cnt = '0;
    end else if (exp_q.size() != 0) begin
      if (out_ready) begin
        if (exp_q[0].l) m_cnt = m_cnt + 32'd1;
        void'(exp_q.pop_front());
      end
    end else if ((|logb_valid) || (|loge_valid)) begin
      push_pkt(logb_valid, loge_valid, logb_data);
    end
  end

  always @(negedge clk) begin
    chk("log_ready", OW'(log_ready), OW'(exp_q.size() == 0));
    chk("out_valid", OW'(out_valid), OW'(exp_q.size() != 0));
    chk("pkt_cnt", OW'(pkt_cnt), OW'(m_cnt));
    if (exp_q.size() != 0) begin
      chk("beat_data", out_data, exp_q[0].d);
      chk("beat_last", OW'(out_last), OW'(exp_q[0].l));
    end
    if (rstn && p_stall) begin
      chk("stall_data", out_data, p_data);
      chk("stall_last", OW'(out_last), OW'(p_last));
    end
    p_stall = rstn && out_valid && !out_ready;
    p_data  = out_data;
    p_last  = out_last;
    if (rstn && out_valid && out_ready) acc_q.push_back('{out_data, out_last});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !log_ready) && n < 50) begin
      tick();
      n++;
    end
    chk(nm, OW'(n < 50), OW'(1));
  endtask

  task automatic rand_data(output logic [DW-1:0] d);
    for (int k = 0; k < DW; k++) d[k] = 1'($urandom_range(0, 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] d;
    int            lows;
    int            highs[$];
    n_checks = 0;
    n_fail = 0;
    p_stall = 1'b0;
    p_data = '0;
    p_last = 1'b0;
    m_cnt = '0;
    rstn = 1'b1;
    logb_valid = '0;
    loge_valid = '0;
    logb_data = '0;
    out_ready = 1'b0;
    #2 rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_log_ready", OW'(log_ready), OW'(1));
    chk("rst_out_valid", OW'(out_valid), OW'(0));
    chk("rst_out_data", out_data, OW'(0));
    chk("rst_out_last", OW'(out_last), OW'(0));
    chk("rst_pkt_cnt", OW'(pkt_cnt), OW'(0));
    rstn = 1'b1;
    tick();

    // All valids, out_ready high
    out_ready = 1'b1;
    acc_q.delete();
    rand_data(d);
    logb_data = d;
    logb_valid = 3'b111;
    loge_valid = 5'b11111;
    tick();
    logb_valid = '0;
    loge_valid = '0;
    drain("all_drain");
    chk("all_beats", OW'(acc_q.size()), OW'(4));
    if (acc_q.size() >= 4) begin
      chk("all_hdr", acc_q[0].d, OW'(8'hFF));
      chk("all_aw", acc_q[1].d, OW'(d[71:0]));
      chk("all_w", acc_q[2].d, OW'(d[367:72]));
      chk("all_ar", acc_q[3].d, OW'(d[439:368]));
      chk("all_last1", OW'(acc_q[0].l), OW'(0));
      chk("all_last4", OW'(acc_q[3].l), OW'(1));
    end
    chk("all_pkt_cnt", OW'(pkt_cnt), OW'(1));

    // Event-only packet
    acc_q.delete();
    loge_valid = 5'b10000;
    tick();
    loge_valid = '0;
    lows = 0;
    for (int c = 0; c < 8; c++) begin
      if (!log_ready) lows++;
      tick();
    end
    chk("loge_ready_low", OW'(lows), OW'(1));
    chk("loge_beats", OW'(acc_q.size()), OW'(1));
    if (acc_q.size() >= 1) begin
      chk("loge_hdr", acc_q[0].d, OW'(8'h80));
      chk("loge_last", OW'(acc_q[0].l), OW'(1));
    end

    // Sparse mask with out_ready toggling
    acc_q.delete();
    rand_data(d);
    logb_data = d;
    out_ready = 1'b0;
    logb_valid = 3'b101;
    tick();
    logb_valid = '0;
    for (int c = 0; c < 16; c++) begin
      out_ready = ~out_ready;
      tick();
    end
    out_ready = 1'b1;
    drain("sparse_drain");
    chk("sparse_beats", OW'(acc_q.size()), OW'(3));
    if (acc_q.size() >= 3) begin
      chk("sparse_hdr", acc_q[0].d, OW'(8'h05));
      chk("sparse_ch0", acc_q[1].d, OW'(d[71:0]));
      chk("sparse_ch2", acc_q[2].d, OW'(d[439:368]));
      chk("sparse_last", OW'({acc_q[0].l, acc_q[1].l, acc_q[2].l}), OW'(3'b001));
    end

    // Valids held high continuously
    acc_q.delete();
    rand_data(d);
    logb_data = d;
    logb_valid = 3'b111;
    loge_valid = 5'b00111;
    for (int c = 0; c < 21; c++) begin
      if (log_ready) highs.push_back(c);
      tick();
    end
    logb_valid = '0;
    loge_valid = '0;
    drain("hold_drain");
    chk("hold_period_cnt", OW'(highs.size() >= 4), OW'(1));
    for (int k = 1; k < highs.size(); k++) begin
      chk("hold_period", OW'(highs[k] - highs[k-1]), OW'(5));
    end
    chk("hold_whole_pkts", OW'(acc_q.size() % 4), OW'(0));
    for (int k = 4; k < acc_q.size(); k++) begin
      chk("hold_same_pkt", acc_q[k].d, acc_q[k%4].d);
    end

    // Reset during the channel-1 data beat
    rand_data(d);
    logb_data = d;
    logb_valid = 3'b111;
    tick();
    logb_valid = '0;
    tick();
    tick();
    chk("pre_rst_ch1", out_data, OW'(d[367:72]));
    rstn = 1'b0;
    #1;
    chk("midrst_valid", OW'(out_valid), OW'(0));
    chk("midrst_data", out_data, OW'(0));
    chk("midrst_last", OW'(out_last), OW'(0));
    chk("midrst_cnt", OW'(pkt_cnt), OW'(0));
    chk("midrst_ready", OW'(log_ready), OW'(1));
    tick();
    rstn = 1'b1;
    tick();
    acc_q.delete();
    rand_data(d);
    logb_data = d;
    logb_valid = 3'b010;
    tick();
    logb_valid = '0;
    drain("post_rst_drain");
    chk("post_rst_beats", OW'(acc_q.size()), OW'(2));
    if (acc_q.size() >= 2) begin
      chk("post_rst_hdr", acc_q[0].d, OW'(8'h02));
      chk("post_rst_w", acc_q[1].d, OW'(d[367:72]));
    end
    chk("post_rst_cnt", OW'(pkt_cnt), OW'(1));

    // Packet counter wrap
    force dut.pkt_cnt_q = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    tick();
    release dut.pkt_cnt_q;
    chk("wrap_preload", OW'(pkt_cnt), OW'(32'hFFFF_FFFF));
    rand_data(d);
    logb_data = d;
    logb_valid = 3'b001;
    tick();
    logb_valid = '0;
    drain("wrap_drain");
    chk("wrap_cnt", OW'(pkt_cnt), OW'(0));

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
